// File: rtl/pipe_dec_pkg.sv
// Shared decode-stage definitions: instruction field positions, immediate
// selection codes and load/store sizing codes.
package pipe_dec_pkg;

    localparam int INSTR_W    = 32;
    localparam int FLD_A_HI   = 25;
    localparam int FLD_A_LO   = 21;
    localparam int FLD_D_HI   = 20;
    localparam int FLD_D_LO   = 16;
    localparam int FLD_B_HI   = 15;
    localparam int FLD_B_LO   = 11;
    localparam int FLD_IMM_HI = 15;
    localparam int FLD_IMM_LO = 0;

    typedef enum logic [1:0] {
        IMM_SEXT   = 2'b00,
        IMM_ZEXT   = 2'b01,
        IMM_LUI    = 2'b10,
        IMM_BRANCH = 2'b11
    } imm_sel_e;

    // Code 2'b11 is unused and treated as a full word.
    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_BYTE = 2'b01,
        SIZE_HALF = 2'b10
    } size_e;

endpackage

// File: rtl/regfile_bypass.sv
// 2-read / 1-write register file with write-first read bypass; register 0 is
// hard-wired to zero.
module regfile_bypass #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_hit;

    assign wr_hit = wr_en && (wr_addr != '0);

    // Without clearing, reset only blocks writes so a write landing on a
    // reset edge is still dropped.
    generate
        if (CLR_ON_RST != 0) begin : g_clr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NREG; i++) begin
                        regs[i] <= '0;
                    end
                end else if (wr_hit) begin
                    regs[wr_addr] <= wr_data;
                end
            end
        end else begin : g_noclr
            always_ff @(posedge clk) begin
                if (rst_n && wr_hit) begin
                    regs[wr_addr] <= wr_data;
                end
            end
        end
    endgenerate

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end else if (wr_hit && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end else if (wr_hit && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/pipe_decstage.sv
// Decode stage: operand read with write-back bypass, immediate generation,
// store sizing, load-use scoreboard and a one-entry valid/ready output register.
module pipe_decstage
    import pipe_dec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int CLR_ON_RST = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [1:0]         imm_sel,
    input  logic               rf_b_sel,
    input  logic [1:0]         st_size,
    input  logic               is_load,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic               wb_sel,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [DATA_W-1:0]  mem_out,
    input  logic [1:0]         ld_size,
    input  logic               ld_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  rf_a,
    output logic [DATA_W-1:0]  rf_b_or_st,
    output logic [DATA_W-1:0]  immed,
    output logic [REG_AW-1:0]  out_dst,
    output logic               out_load,
    output logic               stall
);

    localparam int NREG = 1 << REG_AW;

    logic [REG_AW-1:0] a_addr, d_addr, b_addr;
    logic [15:0]       imm16;
    logic              unused_instr_hi;
    logic [DATA_W-1:0] mem_sized, wb_data;
    logic [DATA_W-1:0] rd_a, rd_b, st_sized, imm_ext;
    logic [NREG-1:0]   pending, pend_set, pend_clr;
    logic              wb_mem_clr, a_haz, b_haz, accept;

    assign a_addr          = REG_AW'(instr[FLD_A_HI:FLD_A_LO]);
    assign d_addr          = REG_AW'(instr[FLD_D_HI:FLD_D_LO]);
    assign b_addr          = rf_b_sel ? d_addr : REG_AW'(instr[FLD_B_HI:FLD_B_LO]);
    assign imm16           = instr[FLD_IMM_HI:FLD_IMM_LO];
    assign unused_instr_hi = ^instr[INSTR_W-1:FLD_A_HI+1];

    always_comb begin
        mem_sized = mem_out;
        case (ld_size)
            SIZE_BYTE: mem_sized = {{(DATA_W-8){ld_signed & mem_out[7]}}, mem_out[7:0]};
            SIZE_HALF: mem_sized = {{(DATA_W-16){ld_signed & mem_out[15]}}, mem_out[15:0]};
            default:   mem_sized = mem_out;
        endcase
    end

    assign wb_data = wb_sel ? mem_sized : alu_out;

    regfile_bypass #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wb_en),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data),
        .rd_addr_a (a_addr),
        .rd_addr_b (b_addr),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b)
    );

    always_comb begin
        st_sized = rd_b;
        case (st_size)
            SIZE_BYTE: st_sized = DATA_W'(rd_b[7:0]);
            SIZE_HALF: st_sized = DATA_W'(rd_b[15:0]);
            default:   st_sized = rd_b;
        endcase
    end

    always_comb begin
        imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
        case (imm_sel)
            IMM_ZEXT:   imm_ext = DATA_W'(imm16);
            IMM_LUI:    imm_ext = DATA_W'({imm16, 16'h0000});
            IMM_BRANCH: imm_ext = {{(DATA_W-18){imm16[15]}}, imm16, 2'b00};
            default:    imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
        endcase
    end

    // A register being written back from memory this cycle is served by the
    // bypass, so it no longer counts as a hazard.
    assign wb_mem_clr = wb_en & wb_sel;
    assign a_haz      = (a_addr != '0) && pending[a_addr] &&
                        !(wb_mem_clr && (wb_addr == a_addr));
    assign b_haz      = (b_addr != '0) && pending[b_addr] &&
                        !(wb_mem_clr && (wb_addr == b_addr));
    assign stall      = in_valid & (a_haz | b_haz);
    assign in_ready   = (~out_valid | out_ready) & ~stall;
    assign accept     = in_valid & in_ready;

    assign pend_clr = wb_mem_clr ? (NREG'(1) << wb_addr) : '0;
    assign pend_set = (accept && is_load && (d_addr != '0)) ? (NREG'(1) << d_addr) : '0;

    // Set is OR-ed in after the clear so a new load wins over a write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            rf_a       <= '0;
            rf_b_or_st <= '0;
            immed      <= '0;
            out_dst    <= '0;
            out_load   <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            rf_a       <= rd_a;
            rf_b_or_st <= st_sized;
            immed      <= imm_ext;
            out_dst    <= d_addr;
            out_load   <= is_load;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: doc/pipe_decstage.md
PIPE_DECSTAGE -- requirements
Module: pipe_decstage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; SHALL be a multiple of 16 and at least 32.
REQ-002 Parameter REG_AW, default 5, register address width; file holds 2^REG_AW registers.
REQ-003 Parameter CLR_ON_RST, default 1, register file cleared by reset when 1.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Clk  in  1  rising-edge clock.
REQ-006 Rst_n  in  1  asynchronous active-low reset.
REQ-007 In_valid  in  1 / In_ready  out  1  decode-input handshake.
REQ-008 Instr  in  32  fields: A addr [25:21], dst/B-alt [20:16], B addr [15:11], imm [15:0].
REQ-009 ImmSel  in  2  00 sign-ext imm, 01 zero-ext imm, 10 imm<<16 (lui), 11 sign-ext imm<<2 (branch).
REQ-010 RF_B_sel  in  1  B read address: 0 Instr[15:11], 1 Instr[20:16].
REQ-011 St_size  in  2  store-data sizing: 00 word, 01 byte, 10 half.
REQ-012 Is_load  in  1  instruction is a load targeting Instr[20:16].
REQ-013 WB_en  in  1 / WB_addr  in  REG_AW / WB_sel  in  1 (0 ALU_out, 1 MEM_out)  write-back port.
REQ-014 ALU_out, MEM_out  in  DATA_W  write-back sources.
REQ-015 Ld_size  in  2 (00 word, 01 byte, 10 half) / Ld_signed  in  1  MEM_out sizing.
REQ-016 Out_valid  out  1 / Out_ready  in  1  decode-output handshake.
REQ-017 RF_A, RF_B_or_st, Immed  out  DATA_W  registered operands; Out_dst  out  REG_AW; Out_load  out  1.
REQ-018 Stall  out  1  source-operand hazard indicator.

Function
REQ-019 Register 0 SHALL read zero; writes to it SHALL be ignored.
REQ-020 Write on rising Clk when WB_en=1 and WB_addr!=0; data = ALU_out (WB_sel=0) or sized MEM_out (WB_sel=1).
REQ-021 Load sizing: byte/half take low 8/16 bits, sign-extended if Ld_signed else zero-extended; word unchanged.
REQ-022 Reads SHALL be write-first: read address equal to an active non-zero WB_addr returns the write data in the same cycle.
REQ-023 Store sizing: RF_B_or_st = B operand with bits above 8 (byte) or 16 (half) zeroed; word unchanged.
REQ-024 Accept = In_valid & In_ready; on accept, outputs capture RF_A, sized B, Immed, Instr[20:16], Is_load; latency 1 cycle.
REQ-025 In_ready = (~Out_valid | Out_ready) & ~Stall.
REQ-026 Out_valid set on accept, cleared when Out_ready=1 without new accept; outputs SHALL hold stable while Out_valid & ~Out_ready.
REQ-027 Scoreboard: one pending bit per register; set on accept of Is_load with dst!=0; cleared on WB_en & WB_sel=1 to that address.
REQ-028 Stall = In_valid & (pending[A addr] | pending[B addr]) for non-zero addresses, excluding any address being cleared this cycle (bypass supplies it).
REQ-029 Simultaneous set and clear of the same pending bit: set SHALL win.
REQ-030 Immed SHALL be DATA_W wide; extension fills all bits above 16.

Reset
REQ-031 Rst_n=0 SHALL immediately zero Out_valid, RF_A, RF_B_or_st, Immed, Out_dst, Out_load and all pending bits.
REQ-032 Register file zeroed on reset when CLR_ON_RST=1, else contents undefined.
REQ-033 A write coincident with reset SHALL be dropped; first accept permitted on the first edge after deassertion.

Structure
REQ-034 ImmSel, size codes and Instr field positions SHALL live in shared package pipe_dec_pkg.
REQ-035 Register file with 2-read/1-write and write-first bypass SHALL be sub-module regfile_bypass.

Verification
REQ-036 Write 7 to r1 and 5 to r2 via ALU_out; decode add (A=1, B=2) -> RF_A=7, RF_B_or_st=5 one cycle after accept.
REQ-037 Same-cycle WB r3=0x0000C00F with decode reading r3 -> RF_A=0x0000C00F (bypass).
REQ-038 MEM_out=0xCF647855, byte load signed into r4 -> r4=0x00000055; half signed -> 0x00007855; MEM_out=0x000000F0 byte signed -> 0xFFFFFFF0.
REQ-039 Imm 0xD807, ImmSel=10 -> Immed=0xD8070000; imm 0x000A, ImmSel=11 -> 0x00000028; imm 0x8000, ImmSel=00 -> 0xFFFF8000.
REQ-040 Load r5 accepted, next instr reads r5 -> Stall=1, In_ready=0 until MEM write-back to r5, then accepted with bypassed value.
REQ-041 Out_ready=0 for 3 cycles with Out_valid=1 -> outputs stable, In_ready=0; reset asserted mid-stall -> Out_valid=0 and pending cleared immediately.
